if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the RV32I pipelined core; sits directly upstream of the combinational instruction memory and feeds the decode stage.
- Owns the program counter, drives the word-aligned fetch address to the instruction memory and takes back its read data in the same cycle.
- Registers instruction, PC and PC+4 into the IF/ID pipeline register.
- Handles stall, flush, branch/jump redirect, halt and fetch faults.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; first fetch address.
IMEM_DEPTH, 64, instruction memory depth in 32-bit words; legal fetch range is word index 0..IMEM_DEPTH-1.
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in instr_d when the IF/ID entry is invalid.

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
stall_f  in  1  hold PC (load-use hazard)
stall_d  in  1  hold IF/ID register
flush_d  in  1  load bubble into IF/ID
redirect_valid  in  1  taken branch/jal from EX; load redirect_target into PC
redirect_target  in  32  new PC
halt_req  in  1  stop fetching (debug/test)
imem_addr  out  32  fetch address to instruction memory (= pc_f)
imem_rdata  in  32  instruction word from memory, combinational on imem_addr
pc_f  out  32  current fetch PC
instr_d  out  32  IF/ID instruction
pc_d  out  32  IF/ID PC
pc_plus4_d  out  32  IF/ID PC+4 (link value for jal)
valid_d  out  1  IF/ID entry holds a real instruction
fault  out  2  00 none, 01 misaligned redirect, 10 fetch out of range; sticky
state_o  out  2  00 BOOT, 01 RUN, 10 HALT

Behaviour:
Reset (async, rst_n=0):
- pc_f=RESET_PC, state=BOOT, instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0, fault=00.
- Reset asserted mid-operation aborts everything immediately.

Fetch address:
- imem_addr=pc_f, combinational.
- PC arithmetic is 32-bit modulo 2^32; pc+4 wraps without flagging.

BOOT:
- One cycle only. pc_f stays RESET_PC, IF/ID loads bubble, next state RUN.
- First valid_d=1 appears two rising edges after reset release.

RUN, per edge, priority high to low:
1. redirect_valid with redirect_target[1:0]!=0:
   - fault=01, state=HALT, pc_f holds, IF/ID loads bubble.
2. redirect_valid, aligned target:
   - pc_f<=redirect_target; IF/ID loads bubble (wrong-path squash). This overrides stall_f and stall_d.
3. halt_req:
   - state=HALT, pc_f holds, IF/ID loads bubble.
4. pc_f[31:2] >= IMEM_DEPTH:
   - fault=10, state=HALT, IF/ID loads bubble; the word is never captured.
5. Normal:
   - pc_f<=pc_f+4 unless stall_f.
   - IF/ID: flush_d loads bubble; else stall_d holds; else loads {imem_rdata, pc_f, pc_f+4} with valid_d=1.
   - flush_d beats stall_d.

Additional rules:
- Bubble means instr_d=NOP_INSTR, valid_d=0; pc_d/pc_plus4_d hold their previous values.
- stall_f=1 with stall_d=0 and no flush captures the same word again; the hazard unit never drives this combination and it is not checked.

HALT:
- pc_f, fault and IF/ID frozen, except valid_d=0 and instr_d=NOP_INSTR.
- Exit only via reset; all inputs ignored.

State encoding:
- state_o reflects the registered state; value 11 is unreachable.
- fault is written only on entry to HALT and holds until reset.

Test Plan:
- Release rst_n, memory returns word index as data, no stalls -> pc_f 0,0,4,8,...; valid_d rises on edge 2 with instr_d=0, pc_d=0, pc_plus4_d=4; next instr_d=1, pc_d=4.
- stall_f=stall_d=1 for 3 cycles at pc_f=0x10 -> pc_f and IF/ID unchanged; release -> pc_d=0x10 captured once, then 0x14.
- redirect_valid, target 0x40, with stall_f=1 at pc_f=0x20 -> next pc_f=0x40, valid_d=0, instr_d=0x00000013; following cycle pc_d=0x40.
- flush_d with stall_d simultaneously -> bubble loaded (valid_d=0), pc_f advances by 4.
- redirect target 0x42 -> fault=01, state_o=10, pc_f frozen, valid_d=0; further redirects ignored; rst_n pulse mid-HALT -> pc_f=RESET_PC, fault=00, state_o=00.
- IMEM_DEPTH=4, free-run -> words 0..3 delivered with valid_d=1, then pc_f=0x10, fault=10, HALT, no fifth valid instruction; halt_req at pc_f=0x8 in a separate run -> HALT, fault=00.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction
// memory and loads the IF/ID pipeline register (stall, flush, redirect, halt, faults).
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH = 64,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d,
    output logic [1:0]  fault,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE    = 2'b10;

    state_t      state, state_nx;
    logic [31:0] pc_nx, instr_nx, pc_d_nx, pc_plus4_nx;
    logic        valid_nx;
    logic [1:0]  fault_nx;
    logic        bubble;
    logic [31:0] pc_f_plus4;
    logic        out_of_range;

    assign imem_addr    = pc_f;
    assign state_o      = state;
    assign pc_f_plus4   = pc_f + 32'd4;
    assign out_of_range = {2'b00, pc_f[31:2]} >= IMEM_DEPTH;

    always_comb begin
        state_nx    = state;
        pc_nx       = pc_f;
        instr_nx    = instr_d;
        pc_d_nx     = pc_d;
        pc_plus4_nx = pc_plus4_d;
        valid_nx    = valid_d;
        fault_nx    = fault;
        bubble      = 1'b0;

        unique case (state)
            BOOT: begin
                bubble   = 1'b1;
                state_nx = RUN;
            end
            RUN: begin
                // Redirects squash the wrong-path word and override both stalls.
                if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
                    fault_nx = FAULT_MISALIGN;
                    state_nx = HALT;
                    bubble   = 1'b1;
                end else if (redirect_valid) begin
                    pc_nx  = redirect_target;
                    bubble = 1'b1;
                end else if (halt_req) begin
                    state_nx = HALT;
                    bubble   = 1'b1;
                end else if (out_of_range) begin
                    fault_nx = FAULT_RANGE;
                    state_nx = HALT;
                    bubble   = 1'b1;
                end else begin
                    if (!stall_f) pc_nx = pc_f_plus4;
                    if (flush_d) begin
                        bubble = 1'b1;
                    end else if (!stall_d) begin
                        instr_nx    = imem_rdata;
                        pc_d_nx     = pc_f;
                        pc_plus4_nx = pc_f_plus4;
                        valid_nx    = 1'b1;
                    end
                end
            end
            HALT: begin
                bubble = 1'b1;
            end
            default: begin
                state_nx = HALT;
                bubble   = 1'b1;
            end
        endcase

        // A bubble leaves pc_d/pc_plus4_d untouched.
        if (bubble) begin
            instr_nx = NOP_INSTR;
            valid_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BOOT;
            pc_f       <= RESET_PC;
            instr_d    <= NOP_INSTR;
            pc_d       <= '0;
            pc_plus4_d <= '0;
            valid_d    <= 1'b0;
            fault      <= FAULT_NONE;
        end else begin
            state      <= state_nx;
            pc_f       <= pc_nx;
            instr_d    <= instr_nx;
            pc_d       <= pc_d_nx;
            pc_plus4_d <= pc_plus4_nx;
            valid_d    <= valid_nx;
            fault      <= fault_nx;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: two instances (IMEM_DEPTH 64 and 4)
// compared every cycle against a rule-level reference model, plus literal checks.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall_f, stall_d, flush_d, redirect_valid, halt_req;
    logic [31:0] redirect_target;

    logic [31:0] mem [64];

    logic [31:0] a_addr, a_rdata, a_pc, a_instr, a_pcd, a_pcp4;
    logic        a_valid;
    logic [1:0]  a_fault, a_state;
    logic [31:0] b_addr, b_rdata, b_pc, b_instr, b_pcd, b_pcp4;
    logic        b_valid;
    logic [1:0]  b_fault, b_state;

    assign a_rdata = mem[a_addr[7:2]];
    assign b_rdata = mem[b_addr[7:2]];

    if_fetch_stage dut_a (
        .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .stall_d(stall_d),
        .flush_d(flush_d), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .halt_req(halt_req),
        .imem_addr(a_addr), .imem_rdata(a_rdata), .pc_f(a_pc),
        .instr_d(a_instr), .pc_d(a_pcd), .pc_plus4_d(a_pcp4),
        .valid_d(a_valid), .fault(a_fault), .state_o(a_state)
    );

    if_fetch_stage #(.IMEM_DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .stall_d(stall_d),
        .flush_d(flush_d), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .halt_req(halt_req),
        .imem_addr(b_addr), .imem_rdata(b_rdata), .pc_f(b_pc),
        .instr_d(b_instr), .pc_d(b_pcd), .pc_plus4_d(b_pcp4),
        .valid_d(b_valid), .fault(b_fault), .state_o(b_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, instr, pcd, pcp4;
        logic        valid;
        logic [1:0]  fault, st;
    } mdl_t;

    mdl_t ma, mb;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    function automatic mdl_t mreset();
        mdl_t m;
        m.pc = 32'h0; m.instr = NOP; m.pcd = 32'h0; m.pcp4 = 32'h0;
        m.valid = 1'b0; m.fault = 2'd0; m.st = 2'd0;
        return m;
    endfunction

    // One rising edge of the fetch stage, written as the plain priority rules.
    function automatic mdl_t mstep(mdl_t m, int unsigned depth, logic [31:0] word);
        mdl_t n = m;
        bit   bub = 1'b0;
        if (m.st == 2'd0) begin
            n.st = 2'd1; bub = 1'b1;
        end else if (m.st == 2'd2) begin
            bub = 1'b1;
        end else if (redirect_valid && redirect_target[1:0] != 2'b00) begin
            n.fault = 2'd1; n.st = 2'd2; bub = 1'b1;
        end else if (redirect_valid) begin
            n.pc = redirect_target; bub = 1'b1;
        end else if (halt_req) begin
            n.st = 2'd2; bub = 1'b1;
        end else if ((m.pc / 4) >= depth) begin
            n.fault = 2'd2; n.st = 2'd2; bub = 1'b1;
        end else begin
            if (!stall_f) n.pc = m.pc + 4;
            if (flush_d) bub = 1'b1;
            else if (!stall_d) begin
                n.instr = word; n.pcd = m.pc; n.pcp4 = m.pc + 4; n.valid = 1'b1;
            end
        end
        if (bub) begin
            n.instr = NOP; n.valid = 1'b0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= mreset();
            mb <= mreset();
        end else begin
            ma <= mstep(ma, 64, mem[ma.pc[7:2]]);
            mb <= mstep(mb, 4, mem[mb.pc[7:2]]);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("a.imem_addr", a_addr, ma.pc);
        check("a.pc_f", a_pc, ma.pc);
        check("a.instr_d", a_instr, ma.instr);
        check("a.pc_d", a_pcd, ma.pcd);
        check("a.pc_plus4_d", a_pcp4, ma.pcp4);
        check("a.valid_d", {31'b0, a_valid}, {31'b0, ma.valid});
        check("a.fault", {30'b0, a_fault}, {30'b0, ma.fault});
        check("a.state_o", {30'b0, a_state}, {30'b0, ma.st});
        check("b.imem_addr", b_addr, mb.pc);
        check("b.pc_f", b_pc, mb.pc);
        check("b.instr_d", b_instr, mb.instr);
        check("b.pc_d", b_pcd, mb.pcd);
        check("b.pc_plus4_d", b_pcp4, mb.pcp4);
        check("b.valid_d", {31'b0, b_valid}, {31'b0, mb.valid});
        check("b.fault", {30'b0, b_fault}, {30'b0, mb.fault});
        check("b.state_o", {30'b0, b_state}, {30'b0, mb.st});
    end

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
        redirect_valid = 1'b0; redirect_target = 32'h0; halt_req = 1'b0;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        for (int i = 0; i < 64; i++) mem[i] = 32'(i);
        #2 rst_n = 1'b0;
        tick(2);
        check("lit.reset_pc", a_pc, 32'h0);
        check("lit.reset_instr", a_instr, NOP);
        check("lit.reset_valid", {31'b0, a_valid}, 32'd0);
        check("lit.reset_state", {30'b0, a_state}, 32'd0);
        rst_n = 1'b1;

        tick(1);
        check("lit.boot_pc", a_pc, 32'h0);
        check("lit.boot_valid", {31'b0, a_valid}, 32'd0);
        tick(1);
        check("lit.first_valid", {31'b0, a_valid}, 32'd1);
        check("lit.first_instr", a_instr, 32'd0);
        check("lit.first_pc_d", a_pcd, 32'h0);
        check("lit.first_pcp4", a_pcp4, 32'h4);
        check("lit.first_pc_f", a_pc, 32'h4);
        tick(1);
        check("lit.second_instr", a_instr, 32'd1);
        check("lit.second_pc_d", a_pcd, 32'h4);
        tick(2);
        check("lit.pc_10", a_pc, 32'h10);

        stall_f = 1'b1; stall_d = 1'b1;
        tick(3);
        check("lit.stall_pc", a_pc, 32'h10);
        check("lit.stall_pc_d", a_pcd, 32'hC);
        check("lit.d4_fault", {30'b0, b_fault}, 32'd2);
        check("lit.d4_state", {30'b0, b_state}, 32'd2);
        check("lit.d4_pc", b_pc, 32'h10);
        check("lit.d4_pc_d", b_pcd, 32'hC);
        idle();
        tick(1);
        check("lit.unstall_pc_d", a_pcd, 32'h10);
        check("lit.unstall_instr", a_instr, 32'd4);
        tick(1);
        check("lit.unstall_pc_d2", a_pcd, 32'h14);
        tick(2);
        check("lit.pc_20", a_pc, 32'h20);

        redirect_valid = 1'b1; redirect_target = 32'h40; stall_f = 1'b1; stall_d = 1'b1;
        tick(1);
        check("lit.redir_pc", a_pc, 32'h40);
        check("lit.redir_valid", {31'b0, a_valid}, 32'd0);
        check("lit.redir_instr", a_instr, NOP);
        idle();
        tick(1);
        check("lit.redir_pc_d", a_pcd, 32'h40);
        check("lit.redir_word", a_instr, 32'd16);

        flush_d = 1'b1; stall_d = 1'b1;
        tick(1);
        check("lit.flush_valid", {31'b0, a_valid}, 32'd0);
        check("lit.flush_pc", a_pc, 32'h48);
        idle();
        tick(1);

        redirect_valid = 1'b1; redirect_target = 32'h42;
        tick(1);
        check("lit.mis_fault", {30'b0, a_fault}, 32'd1);
        check("lit.mis_state", {30'b0, a_state}, 32'd2);
        check("lit.mis_pc", a_pc, 32'h4C);
        redirect_target = 32'h80;
        tick(2);
        check("lit.halt_pc_frozen", a_pc, 32'h4C);
        idle();
        rst_n = 1'b0;
        #1;
        check("lit.rst_mid_pc", a_pc, 32'h0);
        check("lit.rst_mid_fault", {30'b0, a_fault}, 32'd0);
        check("lit.rst_mid_state", {30'b0, a_state}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        tick(3);
        halt_req = 1'b1;
        tick(1);
        halt_req = 1'b0;
        check("lit.halt_state", {30'b0, a_state}, 32'd2);
        check("lit.halt_fault", {30'b0, a_fault}, 32'd0);
        check("lit.halt_pc", a_pc, 32'h8);
        check("lit.halt_d4_state", {30'b0, b_state}, 32'd2);
        tick(2);

        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        reset_pulse();
        for (int unsigned c = 0; c < 3000; c++) begin
            stall_d = ($urandom_range(0, 99) < 15);
            stall_f = stall_d && ($urandom_range(0, 1) == 1);
            flush_d = ($urandom_range(0, 99) < 8);
            redirect_valid = ($urandom_range(0, 99) < 6);
            redirect_target = 32'($urandom_range(0, 75)) << 2;
            if ($urandom_range(0, 9) == 0) redirect_target[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 29) == 0) redirect_target = 32'hFFFF_FFFC;
            halt_req = ($urandom_range(0, 999) < 5);
            if (c % 150 == 149) begin
                idle();
                reset_pulse();
            end else begin
                tick(1);
            end
        end
        idle();
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
